data_memory_lsu: RTL and testbench

Parametrised byte-addressable data memory for the RV32 load/store path. It replaces the word-only, write-only data memory with a full load/store port. The port supports byte, halfword and word accesses, sign- or zero-extension on reads, misalignment and range fault reporting, and a configurable number of wait states. It sits between the execute-stage load/store unit and on-chip RAM behind a valid/ready request and a one-cycle response pulse.

---
 rtl/data_memory_lsu.sv | 156 +++++++++++++++
 tb/tb_data_memory_lsu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressable RV32 data memory behind a valid/ready request port.
// Supports byte/half/word loads and stores, load extension, fault reporting and a fixed
// number of wait states before each access. Responses are a one-cycle rsp_valid pulse.
module data_memory_lsu #(
   parameter int unsigned MEM_SIZE    = 1024,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault
);

   localparam int unsigned IdxW     = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
   localparam logic [29:0] MemWords = 30'(MEM_SIZE);
   localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        accept;
   logic        do_access;

   // Captured request
   logic        we_q;
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [31:0] wdata_q;

   logic [31:0] rsp_rdata_q;
   logic        rsp_fault_q;

   // Contents survive reset; words 0..4 start out holding their own index
   logic [31:0] mem_q [MEM_SIZE] = '{0: 32'd0, 1: 32'd1, 2: 32'd2, 3: 32'd3, 4: 32'd4,
                                     default: 32'd0};

   logic [IdxW-1:0] idx;
   logic [4:0]      bit_off;
   logic [31:0]     rd_word;
   logic [7:0]      lane_b;
   logic [15:0]     lane_h;
   logic [31:0]     load_data;
   logic [31:0]     wr_word;
   logic            fault;

   // State register and wait-state counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and counter logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: if (accept) state_d = StBusy;
         StBusy: begin
            if (cnt_q != 4'd0) cnt_d   = cnt_q - 4'd1;
            else               state_d = StResp;
         end
         StResp: state_d = accept ? StBusy : StIdle;
         default: state_d = StIdle;
      endcase
      if (accept) cnt_d = WaitInit;
   end

   // Handshake outputs decoded from state
   always_comb begin
      req_ready = (state_q != StBusy);
      rsp_valid = (state_q == StResp);
      accept    = req_valid && req_ready;
      do_access = (state_q == StBusy) && (cnt_q == 4'd0);
   end

   // Capture the request on acceptance so inputs may change afterwards
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= req_we;
         addr_q  <= req_addr;
         size_q  <= req_size;
         uns_q   <= req_unsigned;
         wdata_q <= req_wdata;
      end
   end

   // Fault decode, lane extraction and store merge on the captured request
   always_comb begin
      idx     = addr_q[IdxW+1:2];
      bit_off = {addr_q[1:0], 3'b000};
      rd_word = mem_q[idx];
      lane_b  = rd_word[bit_off +: 8];
      lane_h  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

      case (size_q)
         2'b00:   fault = 1'b0;
         2'b01:   fault = addr_q[0];
         2'b10:   fault = |addr_q[1:0];
         default: fault = 1'b1;
      endcase
      if (addr_q[31:2] >= MemWords) fault = 1'b1;

      case (size_q)
         2'b00:   load_data = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
         2'b01:   load_data = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
         default: load_data = rd_word;
      endcase

      wr_word = rd_word;
      case (size_q)
         2'b00: wr_word[bit_off +: 8] = wdata_q[7:0];
         2'b01: begin
            if (addr_q[1]) wr_word[31:16] = wdata_q[15:0];
            else           wr_word[15:0]  = wdata_q[15:0];
         end
         default: wr_word = wdata_q;
      endcase
   end

   // Store write; gated by rst_n so a reset at the access edge drops the store
   always_ff @(posedge clk) begin
      if (rst_n && do_access && we_q && !fault) begin
         mem_q[idx] <= wr_word;
      end
   end

   // Registered response data, held between responses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_rdata_q <= 32'd0;
         rsp_fault_q <= 1'b0;
      end else if (do_access) begin
         rsp_rdata_q <= (fault || we_q) ? 32'd0 : load_data;
         rsp_fault_q <= fault;
      end
   end

   assign rsp_rdata = rsp_rdata_q;
   assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: one instance with no wait states for the functional vectors,
// one with three wait states for latency, back-to-back and reset-during-BUSY sequences.
module tb_data_memory_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_we;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_uns;
   logic [31:0] req_wdata;

   logic        v0, rdy0, rv0, f0;
   logic [31:0] rd0;
   logic        v3, rdy3, rv3, f3;
   logic [31:0] rd3;

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_memory_lsu #(.MEM_SIZE(1024), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rdy0), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_uns),
      .req_wdata(req_wdata), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_fault(f0)
   );

   data_memory_lsu #(.MEM_SIZE(1024), .WAIT_STATES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_uns),
      .req_wdata(req_wdata), .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_fault(f3)
   );

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_flt;
   } vec_t;

   vec_t vq[$];

   task automatic add(input string n, input logic we, input logic [31:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_flt);
      vec_t v;
      v.name = n; v.we = we; v.addr = addr; v.size = size; v.uns = uns;
      v.wdata = wdata; v.exp_rd = exp_rd; v.exp_flt = exp_flt;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Single request on dut0 (sel=0) or dut3 (sel=1); lat is response cycle - accept cycle
   task automatic req(input logic sel, input logic we, input logic [31:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                      output logic [31:0] rd, output logic flt, output int lat);
      int n;
      int c;
      req_we = we; req_addr = addr; req_size = size; req_uns = uns; req_wdata = wdata;
      if (sel) v3 = 1'b1; else v0 = 1'b1;
      n = 0;
      while (!(sel ? rdy3 : rdy0) && n < 50) begin
         @(posedge clk); #1; n++;
      end
      c = cyc;
      @(posedge clk); #1;
      v0 = 1'b0; v3 = 1'b0;
      n = 0;
      while (!(sel ? rv3 : rv0) && n < 50) begin
         @(posedge clk); #1; n++;
      end
      lat = (sel ? rv3 : rv0) ? cyc - c : -1;
      rd  = sel ? rd3 : rd0;
      flt = sel ? f3 : f0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      logic        flt;
      int          lat;
      int          acc, prev_acc, busy, n, seen;

      rst_n = 1'b0; v0 = 1'b0; v3 = 1'b0;
      req_we = 1'b0; req_addr = '0; req_size = 2'b10; req_uns = 1'b0; req_wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      chk("reset ready", {31'd0, rdy0}, 32'd1);
      chk("reset rsp_valid", {31'd0, rv0}, 32'd0);
      chk("reset rdata", rd0, 32'd0);
      chk("reset fault", {31'd0, f0}, 32'd0);

      //   name           we    addr      size   uns   wdata          exp_rd         flt
      add("sw 10",        1'b1, 32'h10,   2'b10, 1'b0, 32'hDEADBEEF, 32'h0,         1'b0);
      add("lw 10",        1'b0, 32'h10,   2'b10, 1'b0, 32'h0,        32'hDEADBEEF,  1'b0);
      add("sb 21",        1'b1, 32'h21,   2'b00, 1'b0, 32'h111111AA, 32'h0,         1'b0);
      add("sh 22",        1'b1, 32'h22,   2'b01, 1'b0, 32'h55551234, 32'h0,         1'b0);
      add("lw 20",        1'b0, 32'h20,   2'b10, 1'b0, 32'h0,        32'h1234AA00,  1'b0);
      add("lb 21",        1'b0, 32'h21,   2'b00, 1'b0, 32'h0,        32'hFFFFFFAA,  1'b0);
      add("lbu 21",       1'b0, 32'h21,   2'b00, 1'b1, 32'h0,        32'h000000AA,  1'b0);
      add("lh 22",        1'b0, 32'h22,   2'b01, 1'b0, 32'h0,        32'h00001234,  1'b0);
      add("sh 32",        1'b1, 32'h32,   2'b01, 1'b0, 32'h00008001, 32'h0,         1'b0);
      add("lh 32",        1'b0, 32'h32,   2'b01, 1'b0, 32'h0,        32'hFFFF8001,  1'b0);
      add("lhu 32",       1'b0, 32'h32,   2'b01, 1'b1, 32'h0,        32'h00008001,  1'b0);
      add("lb 33",        1'b0, 32'h33,   2'b00, 1'b0, 32'h0,        32'hFFFFFF80,  1'b0);
      add("lw 30",        1'b0, 32'h30,   2'b10, 1'b0, 32'h0,        32'h80010000,  1'b0);
      add("lh 03 fault",  1'b0, 32'h03,   2'b01, 1'b0, 32'h0,        32'h0,         1'b1);
      add("lw 02 fault",  1'b0, 32'h02,   2'b10, 1'b0, 32'h0,        32'h0,         1'b1);
      add("size11 fault", 1'b0, 32'h00,   2'b11, 1'b0, 32'h0,        32'h0,         1'b1);
      add("lw 1000 fault",1'b0, 32'h1000, 2'b10, 1'b0, 32'h0,        32'h0,         1'b1);
      add("sw 06 fault",  1'b1, 32'h06,   2'b10, 1'b0, 32'h12345678, 32'h0,         1'b1);
      add("lw 04 after",  1'b0, 32'h04,   2'b10, 1'b0, 32'h0,        32'h00000001,  1'b0);
      add("lw 08 init",   1'b0, 32'h08,   2'b10, 1'b0, 32'h0,        32'h00000002,  1'b0);

      foreach (vq[i]) begin
         req(1'b0, vq[i].we, vq[i].addr, vq[i].size, vq[i].uns, vq[i].wdata, rd, flt, lat);
         chk({vq[i].name, " rdata"}, rd, vq[i].exp_rd);
         chk({vq[i].name, " fault"}, {31'd0, flt}, {31'd0, vq[i].exp_flt});
         chk({vq[i].name, " latency"}, 32'(lat), 32'd2);
      end

      // Reset in RESP with a new request pending: it must not be accepted
      req_we = 1'b0; req_addr = 32'h04; req_size = 2'b10; req_uns = 1'b0; v0 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("resp before reset", {31'd0, rv0}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; v0 = 1'b0;
      chk("reset in resp valid", {31'd0, rv0}, 32'd0);
      chk("reset in resp ready", {31'd0, rdy0}, 32'd1);
      chk("reset in resp rdata", rd0, 32'd0);

      // Back-to-back loads with three wait states, req_valid held high
      req_we = 1'b0; req_size = 2'b10; req_uns = 1'b0; req_addr = 32'h4; v3 = 1'b1;
      acc = cyc;
      prev_acc = 0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         if (k < 4) req_addr = 32'(4 * (k + 1));
         else       v3 = 1'b0;
         busy = 0; n = 0;
         while (!rv3 && n < 20) begin
            if (!rdy3) busy++;
            @(posedge clk); #1; n++;
         end
         chk($sformatf("b2b %0d rdata", k), rd3, 32'(k));
         chk($sformatf("b2b %0d latency", k), 32'(cyc - acc), 32'd5);
         chk($sformatf("b2b %0d ready low", k), 32'(busy), 32'd4);
         if (k > 1) chk($sformatf("b2b %0d interval", k), 32'(acc - prev_acc), 32'd5);
         prev_acc = acc;
         acc = cyc;
      end
      @(posedge clk); #1;
      chk("b2b idle after", {31'd0, rdy3}, 32'd1);

      // Reset during BUSY drops an in-flight store
      req_we = 1'b1; req_addr = 32'h08; req_size = 2'b10; req_wdata = 32'hFFFFFFFF; v3 = 1'b1;
      @(posedge clk); #1;
      v3 = 1'b0;
      seen = rv3;
      @(posedge clk); #1;
      seen = seen | rv3;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("busy reset valid", {31'd0, rv3}, 32'd0);
      chk("busy reset ready", {31'd0, rdy3}, 32'd1);
      chk("busy reset rdata", rd3, 32'd0);
      chk("busy reset fault", {31'd0, f3}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         seen = seen | rv3;
         @(posedge clk); #1;
      end
      chk("busy reset no response", 32'(seen), 32'd0);
      req(1'b1, 1'b0, 32'h08, 2'b10, 1'b0, 32'h0, rd, flt, lat);
      chk("lw 08 after reset", rd, 32'h00000002);
      chk("lw 08 latency", 32'(lat), 32'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
